// File: rtl/vend_ctrl.sv
// vend_ctrl: parametrised coin-accumulating vending controller with cancel/refund.
// Define VEND_STOCK_EN to add the stock counter, restock input and sold_out output.
module vend_ctrl #(
  parameter int PRICE      = 5,
  parameter int VAL_ONE    = 1,
  parameter int VAL_TWO    = 2,
  parameter int VAL_FIVE   = 5,
  parameter int CREDIT_W   = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_one,
  input  logic                coin_two,
  input  logic                coin_five,
  input  logic                cancel,
  output logic                d,
  output logic [CREDIT_W-1:0] r,
  output logic [CREDIT_W-1:0] credit
`ifdef VEND_STOCK_EN
  ,
  input  logic                restock,
  output logic                sold_out
`endif
);
  localparam int VMAX_12 = (VAL_ONE > VAL_TWO) ? VAL_ONE : VAL_TWO;
  localparam int VMAX    = (VMAX_12 > VAL_FIVE) ? VMAX_12 : VAL_FIVE;

  generate
    if (PRICE < 1 || (PRICE - 1 + VMAX) >= (1 << CREDIT_W)) begin : g_param_chk
      $fatal(1, "vend_ctrl: CREDIT_W too narrow for PRICE-1+max coin, or PRICE < 1");
    end
  endgenerate

  localparam logic [CREDIT_W:0]   V1 = (CREDIT_W+1)'(VAL_ONE);
  localparam logic [CREDIT_W:0]   V2 = (CREDIT_W+1)'(VAL_TWO);
  localparam logic [CREDIT_W:0]   V5 = (CREDIT_W+1)'(VAL_FIVE);
  localparam logic [CREDIT_W:0]   PW = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PR = CREDIT_W'(PRICE);

  typedef enum logic [1:0] {IDLE, ACCUM, VEND, REFUND} state_t;

  state_t              state, state_n;
  logic                d_n;
  logic [CREDIT_W-1:0] r_n, credit_n, base;
  logic [CREDIT_W:0]   v, s;
  logic                empty;

  always_comb begin
    v = '0;
    if (coin_one)       v = V1;
    else if (coin_two)  v = V2;
    else if (coin_five) v = V5;
    // Pulse states always start the next transaction from zero credit.
    base     = (state == VEND || state == REFUND) ? '0 : credit;
    s        = {1'b0, base} + v;
    d_n      = 1'b0;
    r_n      = '0;
    credit_n = s[CREDIT_W-1:0];
    state_n  = (s != '0) ? ACCUM : IDLE;
    if (empty && v != '0) begin
      r_n      = v[CREDIT_W-1:0];
      credit_n = base;
      state_n  = REFUND;
    end else if (v != '0 && s >= PW) begin
      d_n      = 1'b1;
      r_n      = s[CREDIT_W-1:0] - PR;  // true difference fits, so modular subtract is exact
      credit_n = '0;
      state_n  = VEND;
    end else if (cancel && s != '0) begin
      r_n      = s[CREDIT_W-1:0];
      credit_n = '0;
      state_n  = REFUND;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      d      <= 1'b0;
      r      <= '0;
      credit <= '0;
    end else begin
      state  <= state_n;
      d      <= d_n;
      r      <= r_n;
      credit <= credit_n;
    end
  end

`ifdef VEND_STOCK_EN
  localparam int            SW = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
  localparam logic [SW-1:0] SI = SW'(STOCK_INIT);

  logic [SW-1:0] stock, stock_n;

  assign empty = (stock == '0);

  // Restock overrides a decrement from a vend in the same cycle.
  always_comb begin
    stock_n = stock;
    if (restock)  stock_n = SI;
    else if (d_n) stock_n = stock - SW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stock    <= SI;
      sold_out <= 1'b0;
    end else begin
      stock    <= stock_n;
      sold_out <= (stock_n == '0);
    end
  end
`else
  assign empty = 1'b0;
`endif

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed plan steps plus random coin/cancel traffic, checked against
// an arithmetic credit model for PRICE=5 and PRICE=7 (and STOCK_INIT=1 with VEND_STOCK_EN).
module tb_vend_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1, coin_one = 1'b0, coin_two = 1'b0, coin_five = 1'b0;
  logic cancel = 1'b0, restock = 1'b0;
  logic [2:0]      d_o;
  logic [2:0][3:0] r_o, cr_o;
  logic [2:0]      so_o;

  always #5 clk = ~clk;

`ifdef VEND_STOCK_EN
  localparam int NI  = 3;
  localparam bit STK = 1'b1;
`else
  localparam int NI  = 2;
  localparam bit STK = 1'b0;
`endif

  int checks = 0, errors = 0;
  int price[3] = '{5, 7, 5};
  int sinit[3] = '{8, 8, 1};
  int m_cred[3], m_r[3], m_stock[3];
  bit m_d[3];

  vend_ctrl #(.PRICE(5), .CREDIT_W(4)) u0 (
    .clk(clk), .reset(reset), .coin_one(coin_one), .coin_two(coin_two),
    .coin_five(coin_five), .cancel(cancel), .d(d_o[0]), .r(r_o[0]), .credit(cr_o[0])
`ifdef VEND_STOCK_EN
    , .restock(restock), .sold_out(so_o[0])
`endif
  );

  vend_ctrl #(.PRICE(7), .CREDIT_W(4)) u1 (
    .clk(clk), .reset(reset), .coin_one(coin_one), .coin_two(coin_two),
    .coin_five(coin_five), .cancel(cancel), .d(d_o[1]), .r(r_o[1]), .credit(cr_o[1])
`ifdef VEND_STOCK_EN
    , .restock(restock), .sold_out(so_o[1])
`endif
  );

`ifdef VEND_STOCK_EN
  vend_ctrl #(.PRICE(5), .CREDIT_W(4), .STOCK_INIT(1)) u2 (
    .clk(clk), .reset(reset), .coin_one(coin_one), .coin_two(coin_two),
    .coin_five(coin_five), .cancel(cancel), .d(d_o[2]), .r(r_o[2]), .credit(cr_o[2]),
    .restock(restock), .sold_out(so_o[2])
  );
`else
  assign d_o[2]  = 1'b0;
  assign r_o[2]  = '0;
  assign cr_o[2] = '0;
  assign so_o    = '0;
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One transaction per cycle, from the rules: coin value, sum, vend / refund / accumulate.
  task automatic model_step();
    int v;
    v = coin_one ? 1 : coin_two ? 2 : coin_five ? 5 : 0;
    for (int k = 0; k < NI; k++) begin
      m_d[k] = 1'b0;
      m_r[k] = 0;
      if (reset) begin
        m_cred[k]  = 0;
        m_stock[k] = sinit[k];
        continue;
      end
      if (STK && m_stock[k] == 0 && v > 0) begin
        m_r[k] = v;
      end else if (v > 0 && m_cred[k] + v >= price[k]) begin
        m_d[k]    = 1'b1;
        m_r[k]    = m_cred[k] + v - price[k];
        m_cred[k] = 0;
        m_stock[k]--;
      end else if (cancel && m_cred[k] + v > 0) begin
        m_r[k]    = m_cred[k] + v;
        m_cred[k] = 0;
      end else begin
        m_cred[k] += v;
      end
      if (restock) m_stock[k] = sinit[k];
    end
  endtask

  task automatic step(input bit o, input bit t, input bit f, input bit c,
                      input bit rs, input bit rst);
    coin_one = o; coin_two = t; coin_five = f; cancel = c; restock = rs; reset = rst;
    @(posedge clk);
    #1;
    model_step();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d.d", k), d_o[k], m_d[k]);
      chk($sformatf("u%0d.r", k), r_o[k], m_r[k]);
      chk($sformatf("u%0d.credit", k), cr_o[k], m_cred[k]);
`ifdef VEND_STOCK_EN
      chk($sformatf("u%0d.sold_out", k), so_o[k], (m_stock[k] == 0) ? 1 : 0);
`endif
    end
  endtask

  initial begin
    // reset and idle
    step(0, 0, 0, 0, 0, 1);
    chk("rst_credit", cr_o[0], 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    chk("idle_d", d_o[0], 0);
    // reset mid-transaction discards credit without refund
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("pre_rst_credit", cr_o[0], 3);
    step(0, 0, 0, 0, 0, 1);
    chk("midrst_credit", cr_o[0], 0);
    chk("midrst_r", r_o[0], 0);
    // one,two,two
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("v122_d", d_o[0], 1);
    chk("v122_r", r_o[0], 0);
    // two,two,five then coin during VEND
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("v225_r", r_o[0], 4);
    step(1, 0, 0, 0, 0, 0);
    chk("b2b_credit", cr_o[0], 1);
    // cancel refund
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("cancel_r", r_o[0], 2);
    chk("cancel_d", d_o[0], 0);
    step(0, 0, 0, 0, 0, 0);
    chk("cancel_r_clr", r_o[0], 0);
    // vend beats cancel
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("vbc_d", d_o[0], 1);
    chk("vbc_r", r_o[0], 3);
    // simultaneous coins, then PRICE=7 five,five
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0);
    chk("prio_credit", cr_o[0], 1);
    chk("prio_d", d_o[0], 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("p7_d", d_o[1], 1);
    chk("p7_r", r_o[1], 3);
`ifdef VEND_STOCK_EN
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0);
    chk("stk_d", d_o[2], 1);
    chk("stk_so", so_o[2], 1);
    step(0, 0, 1, 0, 0, 0);
    chk("stk_rej_r", r_o[2], 5);
    chk("stk_rej_d", d_o[2], 0);
    step(0, 0, 0, 0, 1, 0);
    chk("stk_restock_so", so_o[2], 0);
    step(0, 0, 1, 0, 0, 0);
    chk("stk_again_d", d_o[2], 1);
`endif
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 49) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Parametrised successor to the fixed 5-cent, three-coin vending FSM.
- Price, coin denominations and credit width are parameters.
- Adds a cancel/refund path, a visible credit register, and an optional stock counter with sold-out rejection.
- Sits between the coin acceptor front-end and the dispenser/change-hopper drivers; all outputs are registered.

Parameters:
- PRICE, 5: product price in cents; must be >= 1.
- VAL_ONE, 1: value of coin on coin_one.
- VAL_TWO, 2: value of coin on coin_two.
- VAL_FIVE, 5: value of coin on coin_five.
- CREDIT_W, 4: width of credit and r. Must hold PRICE-1+max(VAL_*); simulation-time check fires $fatal otherwise.
- STOCK_INIT, 8: stock count loaded on reset/restock. Used only with VEND_STOCK_EN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- coin_one  input  1  coin of VAL_ONE inserted this cycle.
- coin_two  input  1  coin of VAL_TWO inserted this cycle.
- coin_five  input  1  coin of VAL_FIVE inserted this cycle.
- cancel  input  1  return accumulated credit.
- d  output  1  dispense pulse, one cycle.
- r  output  CREDIT_W  change/refund amount. Valid for one cycle; 0 otherwise.
- credit  output  CREDIT_W  current accumulated credit.
- restock  input  1  (VEND_STOCK_EN only) reload stock to STOCK_INIT.
- sold_out  output  1  (VEND_STOCK_EN only) stock == 0.

Behaviour:
- Reset: one clock, synchronous, active-high (clk, reset). Clears state to IDLE, credit=0, d=0, r=0. Stock=STOCK_INIT and sold_out=0 when the feature is enabled.
- Reset mid-transaction: credit is discarded and no refund is issued. Reset has priority over all inputs.
- States: IDLE (credit==0), ACCUM (0<credit<PRICE), VEND (d/r pulse cycle), REFUND (r pulse cycle). VEND and REFUND last exactly one cycle.
- Coin decode: at most one coin per cycle. Priority is one > two > five, so v = value of the highest-priority asserted coin (0 if none); lower-priority simultaneous coins are ignored.
- Sum s = credit + v, computed at CREDIT_W+1 bits with no wrap.
- Evaluation order each cycle, in all states:
  1. If v>0 and s>=PRICE: next d=1, r=s-PRICE, credit=0, state VEND. Vend beats a simultaneous cancel.
  2. Else if cancel and s>0: next d=0, r=s, credit=0, state REFUND.
  3. Else: credit=s; state is ACCUM if s>0, otherwise IDLE.
- Pulse cycles: in VEND and REFUND, d/r return to 0 the following cycle unless re-asserted. A coin arriving during a VEND/REFUND cycle is accepted against credit 0, giving back-to-back transactions with no dead cycle.
- Cancel with zero credit and no coin: no effect.
- Latency: coin sampled at edge N produces d/r at edge N+1 and credit at edge N+1.
- Invariant: r <= PRICE-1+max(VAL_*); credit < PRICE outside VEND.

Optional Feature:
- Macro: VEND_STOCK_EN.
- When defined:
  - Adds restock and sold_out ports.
  - Adds a stock counter of width $clog2(STOCK_INIT+1), decremented on each VEND.
  - While stock==0, any accepted coin is returned immediately: next r=v, d=0, credit unchanged (0), state REFUND.
  - restock loads STOCK_INIT. Restock in the same cycle as a vend gives stock=STOCK_INIT; restock wins.
  - sold_out is registered, equal to (stock==0).
- When undefined: no ports, no counter; stock is treated as infinite.

Test Plan:
- Reset then idle 3 cycles -> d=0, r=0, credit=0 each cycle; reset asserted with credit=3 -> credit=0 next cycle, r=0.
- Defaults, coins one,two,two on consecutive cycles -> credit 1,3; cycle after third coin d=1, r=0, credit=0.
- two,two,five -> credit 2,4; then d=1, r=4; coin_one during the VEND cycle -> credit=1 next cycle.
- two, then cancel -> r=2, d=0 for one cycle, credit=0; cancel+five with credit=3 -> d=1, r=3 (vend beats cancel).
- coin_one and coin_five asserted together in IDLE -> credit=1, no vend; PRICE=7, CREDIT_W=4, five,five -> d=1, r=3.
- VEND_STOCK_EN, STOCK_INIT=1: five -> d=1, sold_out=1; five -> r=5, d=0; restock -> sold_out=0; five -> d=1.
